// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding an 8-deep show-ahead FIFO, read and popped by MIO_BUS.
// Everything runs on Clk_CPU. rx_i passes through a two-flop synchroniser first.
//
// state | meaning
// IDLE  | line idle; a low rxs starts a frame unless still inside a break
// START | wait to mid-start bit and confirm it is still low
// DATA  | sample 8 data bits at mid-bit, LSB first
// STOP  | sample the stop bit at mid-bit; push the byte or flag a framing error
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 3
) (
  input  logic               Clk_CPU,
  input  logic               rst,
  input  logic               rx_i,
  input  logic               rd_en,
  input  logic               err_clr,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic [FIFO_AW:0]   rx_count,
  output logic               overrun_err,
  output logic               frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]    HALF_TC  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]    BIT_TC   = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_n;
  logic [BW-1:0]   baud_q, baud_n;
  logic [2:0]      bit_q, bit_n;
  logic [7:0]      shift_q, shift_n;
  logic            brk_q, brk_n;
  logic            rx_meta, rxs;
  logic            push, fe_set;

  logic [7:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
  logic            full, do_pop, do_push;

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      brk_q   <= brk_n;
    end
  end

  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    brk_n   = brk_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_n = '0;
        // after a framing error the line must return high before a new start counts
        if (rxs) brk_n = 1'b0;
        else if (!brk_q) state_n = START;
      end
      START: begin
        if (baud_q == HALF_TC) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BIT_TC) begin
          baud_n  = '0;
          shift_n = {rxs, shift_q[7:1]};
          bit_n   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BIT_TC) begin
          baud_n  = '0;
          state_n = IDLE;
          if (rxs) begin
            push = 1'b1;
          end else begin
            fe_set = 1'b1;
            brk_n  = 1'b1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // a push into a full FIFO is only accepted when a pop frees the head in the same cycle
  assign full     = (rx_count == FULL_CNT);
  assign do_pop   = rd_en & rx_valid;
  assign do_push  = push & (~full | do_pop);
  assign wr_ptr_n = wr_ptr + (FIFO_AW + 1)'(do_push);
  assign rd_ptr_n = rd_ptr + (FIFO_AW + 1)'(do_pop);
  assign count_n  = wr_ptr_n - rd_ptr_n;

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_count    <= '0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      rx_count    <= count_n;
      rx_valid    <= (count_n != '0);
      overrun_err <= (push & ~do_push) | (overrun_err & ~err_clr);
      frame_err   <= fe_set | (frame_err & ~err_clr);
    end
  end

  always_ff @(posedge Clk_CPU) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= shift_q;
  end

  assign rx_data = rx_valid ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 16 clocks per bit, checked against a queue-based model
// of the received byte stream and the two sticky error flags.
module tb_uart_rx_fifo;

  logic       Clk_CPU = 1'b0;
  logic       rst, rx_i, rd_en, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, overrun_err, frame_err;
  logic [3:0] rx_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit         m_ovr, m_fe;

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_AW(3)) dut (
    .Clk_CPU(Clk_CPU), .rst(rst), .rx_i(rx_i), .rd_en(rd_en), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .overrun_err(overrun_err), .frame_err(frame_err)
  );

  always #5 Clk_CPU = ~Clk_CPU;

  // Drives one frame starting at the current falling edge. Edge c counts falling
  // edges from the start bit; the mid-stop sample cycle is the one after edge 154.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit pop_push,
                            input bit clr_stop, input int abort_at,
                            output logic v154, output logic v155, output logic [7:0] popped);
    logic [9:0] bits;
    bit full_b, popped_b;
    bits = {stop, d, 1'b0};
    v154 = 1'b0; v155 = 1'b0; popped = 8'h00;
    for (int c = 0; c < 160; c++) begin
      if (c == abort_at) return;
      if (c == 154) begin v154 = rx_valid; popped = rx_data; end
      if (c == 155) v155 = rx_valid;
      rx_i    = bits[c / 16];
      rd_en   = pop_push && (c == 154);
      err_clr = clr_stop && (c == 154);
      @(negedge Clk_CPU);
    end
    rx_i = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    if (!stop) repeat (4) @(negedge Clk_CPU);
    full_b   = (q.size() == 8);
    popped_b = pop_push && (q.size() > 0);
    if (clr_stop) begin m_fe = 0; m_ovr = 0; end
    if (popped_b) void'(q.pop_front());
    if (stop) begin
      if (!full_b || popped_b) q.push_back(d);
      else m_ovr = 1;
    end else begin
      m_fe = 1;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic stop);
    logic a, b;
    logic [7:0] p;
    send_frame(d, stop, 1'b0, 1'b0, -1, a, b, p);
  endtask

  task automatic pop_byte(output logic [7:0] d, output logic v);
    d = rx_data; v = rx_valid;
    rd_en = 1'b1;
    @(negedge Clk_CPU);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge Clk_CPU);
    err_clr = 1'b0;
    m_ovr = 0; m_fe = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_i = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    q.delete(); m_ovr = 0; m_fe = 0;
    repeat (3) @(negedge Clk_CPU);
    checks++;
    if ({rx_data, rx_valid, rx_count, overrun_err, frame_err} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%0h valid=%0b count=%0d ovr=%0b fe=%0b expected all 0",
               rx_data, rx_valid, rx_count, overrun_err, frame_err);
    end
    rst = 1'b0;
    repeat (3) @(negedge Clk_CPU);
  endtask

  task automatic test_single_byte();
    logic v154, v155, v;
    logic [7:0] p, d;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, v154, v155, p);
    checks++;
    if ({v154, v155} !== 2'b01) begin
      errors++; $display("FAIL single_latency: got valid at c154/c155=%b expected 01", {v154, v155});
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      errors++; $display("FAIL single_head: got valid=%0b data=%0h expected 1 a5", rx_valid, rx_data);
    end
    checks++;
    if (rx_count !== 4'd1 || overrun_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL single_status: got count=%0d ovr=%0b fe=%0b expected 1 0 0",
                         rx_count, overrun_err, frame_err);
    end
    pop_byte(d, v);
    checks++;
    if (rx_valid !== 1'b0 || rx_count !== 4'd0) begin
      errors++; $display("FAIL single_pop: got valid=%0b count=%0d expected 0 0", rx_valid, rx_count);
    end
    pop_byte(d, v);
    checks++;
    if (rx_count !== 4'd0 || rx_valid !== 1'b0 || overrun_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL empty_pop_ignored: got count=%0d valid=%0b ovr=%0b fe=%0b expected 0 0 0 0",
                         rx_count, rx_valid, overrun_err, frame_err);
    end
  endtask

  task automatic test_fill_overrun();
    logic [7:0] d;
    logic v;
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b1);
    frame(8'hFF, 1'b1);
    checks++;
    if (rx_count !== 4'd8 || overrun_err !== 1'b1 || frame_err !== 1'b0) begin
      errors++; $display("FAIL fill_status: got count=%0d ovr=%0b fe=%0b expected 8 1 0",
                         rx_count, overrun_err, frame_err);
    end
    for (int i = 0; i < 8; i++) begin
      pop_byte(d, v);
      checks++;
      if (v !== 1'b1 || d !== 8'(i)) begin
        errors++; $display("FAIL fill_pop%0d: got valid=%0b data=%0h expected 1 %0h", i, v, d, i);
      end
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_count !== 4'd0) begin
      errors++; $display("FAIL fill_drained: got valid=%0b count=%0d expected 0 0", rx_valid, rx_count);
    end
    pulse_clr();
    checks++;
    if (overrun_err !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %0b expected 0", overrun_err);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d, p;
    logic v, a, b;
    frame(8'h11, 1'b1);
    frame(8'h3C, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || rx_count !== 4'd1 || overrun_err !== 1'b0) begin
      errors++; $display("FAIL ferr_set: got fe=%0b count=%0d ovr=%0b expected 1 1 0",
                         frame_err, rx_count, overrun_err);
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL ferr_clear: got %0b expected 0", frame_err);
    end
    frame(8'h5A, 1'b1);
    pop_byte(d, v);
    checks++;
    if (d !== 8'h11) begin
      errors++; $display("FAIL ferr_first: got %0h expected 11", d);
    end
    checks++;
    if (rx_data !== 8'h5A || rx_count !== 4'd1 || frame_err !== 1'b0) begin
      errors++; $display("FAIL ferr_next: got data=%0h count=%0d fe=%0b expected 5a 1 0",
                         rx_data, rx_count, frame_err);
    end
    pop_byte(d, v);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, a, b, p);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL ferr_set_wins: got %0b expected 1", frame_err);
    end
    pulse_clr();
  endtask

  task automatic test_break();
    logic [7:0] d;
    logic v;
    rx_i = 1'b0;
    repeat (200) @(negedge Clk_CPU);
    checks++;
    if (frame_err !== 1'b1 || rx_count !== 4'd0) begin
      errors++; $display("FAIL break_first: got fe=%0b count=%0d expected 1 0", frame_err, rx_count);
    end
    pulse_clr();
    repeat (300) @(negedge Clk_CPU);
    checks++;
    if (frame_err !== 1'b0 || rx_count !== 4'd0) begin
      errors++; $display("FAIL break_single: got fe=%0b count=%0d expected 0 0", frame_err, rx_count);
    end
    rx_i = 1'b1;
    repeat (20) @(negedge Clk_CPU);
    frame(8'h77, 1'b1);
    checks++;
    if (rx_data !== 8'h77 || rx_count !== 4'd1) begin
      errors++; $display("FAIL break_recover: got data=%0h count=%0d expected 77 1", rx_data, rx_count);
    end
    pop_byte(d, v);
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic v;
    rx_i = 1'b0;
    repeat (4) @(negedge Clk_CPU);
    rx_i = 1'b1;
    repeat (40) @(negedge Clk_CPU);
    checks++;
    if (rx_count !== 4'd0 || rx_valid !== 1'b0 || overrun_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL glitch: got count=%0d valid=%0b ovr=%0b fe=%0b expected 0 0 0 0",
                         rx_count, rx_valid, overrun_err, frame_err);
    end
    frame(8'hC3, 1'b1);
    checks++;
    if (rx_data !== 8'hC3 || rx_count !== 4'd1) begin
      errors++; $display("FAIL glitch_next: got data=%0h count=%0d expected c3 1", rx_data, rx_count);
    end
    pop_byte(d, v);
  endtask

  task automatic test_full_simul_pop();
    logic [7:0] d, p;
    logic v, a, b;
    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b1);
    send_frame(8'h99, 1'b1, 1'b1, 1'b0, -1, a, b, p);
    checks++;
    if (rx_count !== 4'd8 || overrun_err !== 1'b0) begin
      errors++; $display("FAIL simul_status: got count=%0d ovr=%0b expected 8 0", rx_count, overrun_err);
    end
    checks++;
    if (p !== 8'h10 || rx_data !== 8'h11) begin
      errors++; $display("FAIL simul_head: got popped=%0h head=%0h expected 10 11", p, rx_data);
    end
    for (int i = 0; i < 8; i++) begin
      pop_byte(d, v);
      checks++;
      if (d !== ((i == 7) ? 8'h99 : 8'h11 + 8'(i))) begin
        errors++; $display("FAIL simul_pop%0d: got %0h expected %0h", i, d,
                           (i == 7) ? 8'h99 : 8'h11 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d, p;
    logic v, a, b;
    frame(8'h33, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 16 * 5 + 5, a, b, p);
    rst = 1'b1;
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_count, overrun_err, frame_err} !== 15'h0) begin
      errors++; $display("FAIL midreset_outputs: got data=%0h valid=%0b count=%0d ovr=%0b fe=%0b expected all 0",
                         rx_data, rx_valid, rx_count, overrun_err, frame_err);
    end
    q.delete(); m_ovr = 0; m_fe = 0;
    @(negedge Clk_CPU);
    rx_i = 1'b1;
    repeat (3) @(negedge Clk_CPU);
    rst = 1'b0;
    repeat (5) @(negedge Clk_CPU);
    frame(8'h42, 1'b1);
    checks++;
    if (rx_data !== 8'h42 || rx_count !== 4'd1 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_next: got data=%0h count=%0d valid=%0b expected 42 1 1",
                         rx_data, rx_count, rx_valid);
    end
    pop_byte(d, v);
  endtask

  task automatic test_random();
    logic [7:0] d, p, exp_d;
    logic v, a, b, stop;
    bit pp, exp_v;
    int npop;
    for (int it = 0; it < 30; it++) begin
      stop = ($urandom_range(0, 5) != 0);
      pp   = ($urandom_range(0, 3) == 0);
      send_frame(8'($urandom), stop, pp, 1'b0, -1, a, b, p);
      checks++;
      if (rx_count !== 4'(q.size()) || rx_valid !== (q.size() > 0) ||
          overrun_err !== m_ovr || frame_err !== m_fe) begin
        errors++; $display("FAIL rand_status%0d: got count=%0d valid=%0b ovr=%0b fe=%0b expected %0d %0b %0b %0b",
                           it, rx_count, rx_valid, overrun_err, frame_err, q.size(), q.size() > 0, m_ovr, m_fe);
      end
      npop = $urandom_range(0, 3);
      for (int k = 0; k < npop; k++) begin
        exp_v = (q.size() > 0);
        exp_d = exp_v ? q[0] : 8'h00;
        pop_byte(d, v);
        checks++;
        if (v !== exp_v || (exp_v && d !== exp_d)) begin
          errors++; $display("FAIL rand_pop%0d_%0d: got valid=%0b data=%0h expected %0b %0h",
                             it, k, v, d, exp_v, exp_d);
        end
      end
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end
    while (q.size() > 0) pop_byte(d, v);
    pulse_clr();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overrun();
    test_frame_err();
    test_break();
    test_glitch();
    test_full_simul_pop();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial UART receiver that pairs with the existing transmit-side uart block.
- Deserialises 8N1 frames from rx_i and buffers the received bytes in a small show-ahead FIFO.
- Exposes the FIFO head, status and sticky error flags to MIO_BUS as memory-mapped read data; MIO_BUS pops a byte when the CPU reads the data register.
- Runs entirely in the Clk_CPU domain.

Parameters:
- CLKS_PER_BIT, 868, Clk_CPU cycles per serial bit; must be >= 4. Benches override it to 16.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.

Ports:
- Clk_CPU  input  1  CPU clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_i  input  1  serial line; idles high; asynchronous to Clk_CPU.
- rd_en  input  1  pop strobe from MIO_BUS, one cycle per CPU read of the data register.
- err_clr  input  1  clears both sticky error flags.
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  output  1  FIFO non-empty.
- rx_count  output  FIFO_AW+1  number of bytes held, 0..8.
- overrun_err  output  1  sticky; a received byte was dropped because the FIFO was full.
- frame_err  output  1  sticky; a stop bit was sampled low.

Behaviour:
- Reset:
  - Synchroniser flops reset to 1.
  - FSM goes to IDLE; FIFO pointers, rx_count, both error flags, bit counter and baud counter go to 0.
  - rx_data reads 0 and rx_valid reads 0.
  - Reset asserted mid-frame discards the partial byte and leaves FIFO contents lost.
- Input sync: two-flop synchroniser on rx_i; all logic uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - rxs=0 → enter START, baud counter=0.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer division) to reach the mid-start point.
  - rxs=1 at mid-start → false start; return to IDLE with no error.
  - rxs=0 at mid-start → enter DATA with baud counter=0 and bit counter=0.
- DATA:
  - Sample rxs each time the baud counter reaches CLKS_PER_BIT-1 (mid-bit).
  - Shift samples in LSB first.
  - After the 8th sample, enter STOP.
- STOP:
  - Sample at the next mid-bit.
  - rxs=1 → push the shift register into the FIFO, then IDLE.
  - rxs=0 → set frame_err, discard the byte, then IDLE. IDLE then waits for rxs to go high before any new start can be detected; a held-low line (break) produces exactly one frame_err.
  - The FSM returns to IDLE at mid-stop, which allows back-to-back frames.
- Latency: the pushed byte appears at rx_data with rx_valid=1 in the cycle after the mid-stop sample cycle.
- FIFO:
  - Show-ahead: rx_data = mem[rd_ptr].
  - Pointers are FIFO_AW+1 bits and wrap naturally.
  - rx_count = wr_ptr - rd_ptr.
- Pop: rd_en with rx_valid=1 advances rd_ptr. rd_en with rx_valid=0 is ignored; no underflow and no error.
- Push when full:
  - rd_en=1 in the same cycle → both push and pop happen; rx_count stays 8.
  - rd_en=0 → the byte is dropped, overrun_err is set, FIFO is unchanged.
- Push and pop in the same cycle when not full: both happen; rx_count is unchanged.
- Error flags:
  - Set by their event; cleared by err_clr.
  - A set event and err_clr in the same cycle → the flag ends at 1 (set wins).
- rx_count, rx_valid and the error flags are registered outputs.

Test Plan:
- Single byte (CLKS_PER_BIT=16): drive frame 0xA5 at 16 cycles/bit → rx_valid=1, rx_data=0xA5, rx_count=1, both error flags 0. Pulse rd_en → rx_valid=0, rx_count=0.
- Fill/overrun: send 0x00..0x07 back-to-back, then 0xFF with no pops → rx_count=8, overrun_err=1. Eight pops return 0x00..0x07 in order; 0xFF is never seen.
- Framing error: send 0x3C with stop bit driven 0 → frame_err=1, rx_count unchanged. err_clr → frame_err=0. The next clean frame 0x5A is received correctly.
- Glitch rejection: drive rx_i low for 4 cycles (less than CLKS_PER_BIT/2), then high → FSM returns to IDLE, rx_count=0, no errors.
- Full with simultaneous pop: FIFO full of 0x10..0x17, pulse rd_en in the same cycle as the push of 0x99 → rx_count=8, overrun_err=0. Head becomes 0x11, and the last entry popped is 0x99.
- Reset mid-frame: assert rst during DATA bit 4 of frame 0x81 → all outputs 0. After reset is released, frame 0x42 is received as 0x42 with rx_count=1.
